// File: rtl/cb_pkg.sv
// Shared definitions for the in-order completion buffer.
// Contents: buffer geometry constants and the per-entry record.
package cb_pkg;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic              valid;
        logic              finished;
        logic              wr;
        logic [ADDR_W-1:0] rd;
    } cbEntry_t;

endpackage

// File: rtl/cb_retire_select.sv
// Combinational retire selection for the completion buffer.
// Ports:
//   headEntry, nextEntry : registered entries at head and head+1
//   head                 : current head pointer
//   r0, r1               : head / head+1 retire this cycle
//   updEnA/B, updAddrA/B : next-cycle ARF update strobes and addresses
//   headNext             : head advanced by the number of retiring entries
module cb_retire_select
    import cb_pkg::*;
(
    input  cbEntry_t          headEntry,
    input  cbEntry_t          nextEntry,
    input  logic [TAG_W-1:0]  head,
    output logic              r0,
    output logic              r1,
    output logic              updEnA,
    output logic              updEnB,
    output logic [ADDR_W-1:0] updAddrA,
    output logic [ADDR_W-1:0] updAddrB,
    output logic [TAG_W-1:0]  headNext
);

    logic sameRd;

    always_comb begin
        // Two commits to the same GPR in one cycle would leave the result to the
        // register file's port priority; split them so the younger lands last.
        sameRd   = headEntry.wr & nextEntry.wr & (headEntry.rd == nextEntry.rd);
        r0       = headEntry.valid & headEntry.finished;
        r1       = r0 & nextEntry.valid & nextEntry.finished & ~sameRd;
        updEnA   = r0 & headEntry.wr;
        updEnB   = r1 & nextEntry.wr;
        updAddrA = headEntry.rd;
        updAddrB = nextEntry.rd;
        headNext = head + TAG_W'(r0) + TAG_W'(r1);
    end

endmodule

// File: rtl/completion_buffer.sv
// In-order completion buffer: allocates up to two entries per cycle in program
// order, marks them finished out of order, and retires up to two per cycle from
// the head, driving registered ARF update strobes.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   disp_en_A/B, disp_wr_A/B, disp_rd_A/B : dispatch (B only with A)
//   disp_ready, disp_tag_A/B           : allocation status and assigned tags
//   fin_en_A/B, fin_tag_A/B            : execution writeback
//   flush                              : discard all entries
//   updateEnA/B, updateAddrA/B         : registered ARF commit interface
//   count                              : occupied entries
module completion_buffer
    import cb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_en_A,
    input  logic              disp_en_B,
    input  logic              disp_wr_A,
    input  logic              disp_wr_B,
    input  logic [ADDR_W-1:0] disp_rd_A,
    input  logic [ADDR_W-1:0] disp_rd_B,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag_A,
    output logic [TAG_W-1:0]  disp_tag_B,
    input  logic              fin_en_A,
    input  logic              fin_en_B,
    input  logic [TAG_W-1:0]  fin_tag_A,
    input  logic [TAG_W-1:0]  fin_tag_B,
    input  logic              flush,
    output logic              updateEnA,
    output logic              updateEnB,
    output logic [ADDR_W-1:0] updateAddrA,
    output logic [ADDR_W-1:0] updateAddrB,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - 2);

    cbEntry_t          entries [DEPTH];
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W-1:0]  headP1;
    logic [TAG_W-1:0]  tailP1;
    logic [TAG_W-1:0]  headNext;
    logic              r0;
    logic              r1;
    logic              updEnA;
    logic              updEnB;
    logic [ADDR_W-1:0] updAddrA;
    logic [ADDR_W-1:0] updAddrB;
    logic              dispAccept;
    logic [TAG_W:0]    nDisp;
    logic [TAG_W:0]    nRet;

    assign headP1     = head + TAG_W'(1);
    assign tailP1     = tail + TAG_W'(1);
    // Uses the pre-edge count only, so two free slots are guaranteed even when
    // nothing retires this cycle; a dispatch can never land on a live entry.
    assign disp_ready = (count <= READY_MAX);
    assign disp_tag_A = tail;
    assign disp_tag_B = tailP1;
    assign dispAccept = disp_en_A & disp_ready;
    assign nDisp      = (TAG_W+1)'(dispAccept) + (TAG_W+1)'(dispAccept & disp_en_B);
    assign nRet       = (TAG_W+1)'(r0) + (TAG_W+1)'(r1);

    cb_retire_select uSel (
        .headEntry (entries[head]),
        .nextEntry (entries[headP1]),
        .head      (head),
        .r0        (r0),
        .r1        (r1),
        .updEnA    (updEnA),
        .updEnB    (updEnB),
        .updAddrA  (updAddrA),
        .updAddrB  (updAddrB),
        .headNext  (headNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            updateEnA   <= 1'b0;
            updateEnB   <= 1'b0;
            updateAddrA <= '0;
            updateAddrB <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].finished <= 1'b0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            updateEnA <= 1'b0;
            updateEnB <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid &&
                    ((fin_en_A && fin_tag_A == TAG_W'(i)) ||
                     (fin_en_B && fin_tag_B == TAG_W'(i))))
                    entries[i].finished <= 1'b1;
            end
            // Retire clears after the finish update so a retiring entry ends empty.
            if (r0) begin
                entries[head].valid    <= 1'b0;
                entries[head].finished <= 1'b0;
            end
            if (r1) begin
                entries[headP1].valid    <= 1'b0;
                entries[headP1].finished <= 1'b0;
            end
            if (dispAccept) begin
                entries[tail] <= '{valid: 1'b1, finished: 1'b0, wr: disp_wr_A, rd: disp_rd_A};
                if (disp_en_B)
                    entries[tailP1] <= '{valid: 1'b1, finished: 1'b0, wr: disp_wr_B, rd: disp_rd_B};
            end
            head      <= headNext;
            tail      <= tail + TAG_W'(nDisp);
            count     <= count + nDisp - nRet;
            updateEnA <= updEnA;
            updateEnB <= updEnB;
            if (updEnA) updateAddrA <= updAddrA;
            if (updEnB) updateAddrB <= updAddrB;
        end
    end

endmodule
